// File: rtl/snake_pkg.sv
// snake_pkg: shared heading type, heading constants and helpers for the
// snake direction controller and the game logic that consumes its heading.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    // Opposite heading: the encoding puts opposites two apart, so flipping
    // the upper bit is enough.
    function automatic dir_t dir_opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// btn_debounce_cell: debounces one raw, asynchronous, active-high button.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   raw   in  raw button level
//   clean out debounced level; rises after 2^DB_CNT_W consecutive high samples
// A single input flop re-times the pin before the counter sees it; that
// stage is what places the rise of clean at edge k + DB_MAX + 1 for a
// button first sampled high at edge k.
module btn_debounce_cell #(
    parameter int DB_CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam logic [DB_CNT_W-1:0] DB_MAX = {DB_CNT_W{1'b1}};

    logic                sync;
    logic [DB_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            sync <= raw;
            if (!sync) begin
                // any low sample restarts the count
                cnt   <= '0;
                clean <= 1'b0;
            end else if (cnt != DB_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                clean <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns four raw direction buttons into a queue of legal
// heading changes and owns the current snake heading.
//   clk, rst                      clock, synchronous active-high reset
//   btn_up/right/down/left        raw active-high buttons
//   tick                          game-step strobe; pops one queued turn
//   dir                           current heading (UP=0 RIGHT=1 DOWN=2 LEFT=3)
//   dir_changed                   one-cycle pulse when dir takes a new value
//   reject                        one-cycle pulse when a press is discarded
//   q_count                       number of queued turns (0..QDEPTH)
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DB_CNT_W = 8,
    parameter int QDEPTH   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       tick,
    output dir_t       dir,
    output logic       dir_changed,
    output logic       reject,
    output logic [2:0] q_count
);

    // Button index equals the heading encoding, so a winning index is
    // directly the candidate heading.
    logic [3:0] raw, clean, clean_d, press;
    assign raw = {btn_left, btn_down, btn_right, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce_cell #(.DB_CNT_W(DB_CNT_W)) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .clean(clean[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) clean_d <= '0;
        else     clean_d <= clean;
    end

    assign press = clean & ~clean_d;

    // Fixed priority UP > RIGHT > DOWN > LEFT; losers are dropped silently.
    logic cand_vld;
    dir_t cand;
    always_comb begin
        cand_vld = |press;
        cand     = DIR_UP;
        if      (press[0]) cand = DIR_UP;
        else if (press[1]) cand = DIR_RIGHT;
        else if (press[2]) cand = DIR_DOWN;
        else if (press[3]) cand = DIR_LEFT;
    end

    // Circular turn queue, sized for the largest allowed depth.
    dir_t       q [4];
    logic [1:0] head, tail, tail_prev;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign tail_prev = (tail == 2'd0) ? 2'(QDEPTH - 1) : tail - 2'd1;

    // Legality is judged against the last heading the snake will have once
    // everything already queued has been applied.
    dir_t ref_dir;
    logic full, pop, bad, push;
    assign ref_dir = (q_count != 3'd0) ? q[tail_prev] : dir;
    assign full    = (q_count == 3'(QDEPTH));
    assign pop     = tick && (q_count != 3'd0);
    assign bad     = (cand == ref_dir) || (cand == dir_opposite(ref_dir)) || (full && !pop);
    assign push    = cand_vld && !bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir         <= DIR_RESET;
            dir_changed <= 1'b0;
            reject      <= 1'b0;
            q_count     <= 3'd0;
            head        <= 2'd0;
            tail        <= 2'd0;
            for (int i = 0; i < 4; i++) q[i] <= DIR_RESET;
        end else begin
            dir_changed <= pop;
            reject      <= cand_vld && bad;
            // A full queue reads the head before the push overwrites that slot.
            if (pop) begin
                dir  <= q[head];
                head <= ptr_inc(head);
            end
            if (push) begin
                q[tail] <= cand;
                tail    <= ptr_inc(tail);
            end
            q_count <= q_count + 3'(push) - 3'(pop);
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;

    localparam int DBW = 2;
    localparam int QD  = 2;
    localparam int N   = (1 << DBW);   // consecutive high samples before clean

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir;
    logic       dir_changed, reject;
    logic [2:0] q_count;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.DB_CNT_W(DBW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
        .tick(tick), .dir(dir), .dir_changed(dir_changed), .reject(reject), .q_count(q_count)
    );

    // Reference model: run length of consecutive high samples per button
    // at the last three edges, a queue of headings, and the heading.
    int         run1[4], run2[4], run3[4];
    logic [1:0] m_dir = 2'd1;
    logic [1:0] mq[$];
    int         m_dc = 0, m_rej = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [3:0] b, input bit t);
        bit         pr[4];
        int         c;
        logic [1:0] rf;
        bit         popm, badm;
        if (r) begin
            for (int i = 0; i < 4; i++) begin run1[i] = 0; run2[i] = 0; run3[i] = 0; end
            mq.delete();
            m_dir = 2'd1; m_dc = 0; m_rej = 0;
            return;
        end
        // press seen at this edge: button became clean one cycle earlier
        for (int i = 0; i < 4; i++) pr[i] = (run2[i] >= N) && (run3[i] < N);
        for (int i = 0; i < 4; i++) begin
            run3[i] = run2[i];
            run2[i] = run1[i];
            run1[i] = b[i] ? ((run1[i] < 1000) ? run1[i] + 1 : run1[i]) : 0;
        end
        c = -1;
        for (int i = 3; i >= 0; i--) if (pr[i]) c = i;
        rf   = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
        popm = t && (mq.size() > 0);
        m_rej = 0;
        m_dc  = popm;
        badm  = 0;
        if (c >= 0) begin
            badm = (c == int'(rf)) || (c == int'(rf ^ 2'b10)) || (mq.size() == QD && !popm);
            m_rej = badm;
        end
        if (popm) m_dir = mq.pop_front();
        if (c >= 0 && !badm) mq.push_back(2'(c));
    endtask

    task automatic step(input bit r, input logic [3:0] b, input bit t);
        rst = r;
        {btn_left, btn_down, btn_right, btn_up} = b;
        tick = t;
        @(posedge clk);
        model_edge(r, b, t);
        @(negedge clk);
        chk("dir", dir, m_dir);
        chk("q_count", q_count, mq.size());
        chk("dir_changed", dir_changed, m_dc);
        chk("reject", reject, m_rej);
    endtask

    // hold a button set long enough for one press, then release
    task automatic press_btn(input logic [3:0] b);
        repeat (N + 3) step(0, b, 0);
        repeat (2) step(0, 4'b0, 0);
    endtask

    task automatic do_reset();
        repeat (3) step(1, 4'b0, 0);
    endtask

    initial begin
        @(negedge clk);

        // reset defaults
        do_reset();
        chk("rst_dir", dir, 1);
        chk("rst_qcnt", q_count, 0);
        chk("rst_pulses", {dir_changed, reject}, 0);

        // debounce of UP, then pop
        repeat (N + 1) step(0, 4'b0001, 0);
        chk("db_early_qcnt", q_count, 0);
        step(0, 4'b0001, 0);
        chk("db_qcnt", q_count, 1);
        chk("db_rej", reject, 0);
        repeat (3) step(0, 4'b0001, 0);
        chk("db_held_once", q_count, 1);
        step(0, 4'b0, 1);
        chk("pop_dir", dir, 0);
        chk("pop_pulse", dir_changed, 1);
        step(0, 4'b0, 0);
        chk("pop_pulse_once", dir_changed, 0);

        // glitches of two cycles never debounce
        repeat (3) begin
            step(0, 4'b0100, 0); step(0, 4'b0100, 0);
            step(0, 4'b0, 0);    step(0, 4'b0, 0);
        end
        chk("glitch_qcnt", q_count, 0);

        // illegal turns from RIGHT
        do_reset();
        press_btn(4'b1000);               // LEFT: reversal
        press_btn(4'b0010);               // RIGHT: repeat
        chk("illegal_qcnt", q_count, 0);
        press_btn(4'b0100);               // DOWN: accepted
        chk("legal_qcnt", q_count, 1);

        // queue order and overflow
        do_reset();
        press_btn(4'b0001);
        press_btn(4'b1000);
        chk("full_qcnt", q_count, 2);
        press_btn(4'b0100);               // full -> rejected
        chk("full_keep", q_count, 2);
        step(0, 4'b0, 1);
        chk("order1", dir, 0);
        step(0, 4'b0, 1);
        chk("order2", dir, 3);

        // simultaneous UP and DOWN
        do_reset();
        press_btn(4'b0101);
        chk("simul_qcnt", q_count, 1);

        // push/pop collision on a full queue
        do_reset();
        press_btn(4'b0001);
        press_btn(4'b1000);
        repeat (N + 1) step(0, 4'b0100, 0);
        step(0, 4'b0100, 1);
        chk("coll_qcnt", q_count, 2);
        chk("coll_dir", dir, 0);
        chk("coll_rej", reject, 0);
        repeat (2) step(0, 4'b0, 0);

        // reset while LEFT is held -> re-debounce, reversal from RIGHT
        do_reset();
        press_btn(4'b0001);
        repeat (3) step(0, 4'b1000, 0);
        repeat (2) step(1, 4'b1000, 0);
        repeat (N + 4) step(0, 4'b1000, 0);
        chk("rstmid_dir", dir, 1);
        chk("rstmid_qcnt", q_count, 0);
        repeat (2) step(0, 4'b0, 0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] b;
            int         len;
            b   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) b = 4'b0;
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++)
                step(($urandom_range(0, 199) == 0), b, ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
